// File: rtl/arctos_isa_pkg.sv
// Arctos32 ISA definitions shared by the decode stage: opcodes, ALU/branch codes,
// instruction field positions and the decoded-field record held in the output register.
package arctos_isa_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;

  localparam logic [2:0] OP_RR      = 3'b000;
  localparam logic [2:0] OP_IMM     = 3'b001;
  localparam logic [2:0] OP_LOADIMM = 3'b010;
  localparam logic [2:0] OP_MEM     = 3'b011;
  localparam logic [2:0] OP_BRANCH  = 3'b100;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;

  localparam logic [1:0] BR_EQ  = 2'b00;
  localparam logic [1:0] BR_NE  = 2'b01;
  localparam logic [1:0] BR_LT  = 2'b10;
  localparam logic [1:0] BR_JMP = 2'b11;

  localparam int OPC_HI   = 31, OPC_LO   = 29;
  localparam int FUNC_HI  = 28, FUNC_LO  = 25;
  localparam int RD_HI    = 24, RD_LO    = 20;
  localparam int RS1_HI   = 19, RS1_LO   = 15;
  localparam int RS2_HI   = 14, RS2_LO   = 10;
  localparam int LIRD_HI  = 28, LIRD_LO  = 24;
  localparam int MEMRW_B  = 28;
  localparam int MEMREG_HI = 27, MEMREG_LO = 23;
  localparam int BTYPE_HI = 28, BTYPE_LO = 27;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [3:0]       alu_func;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             mem_rw;
    logic [22:0]      mem_addr;
    logic [1:0]       branch_type;
    logic [26:0]      inst_addr;
    logic             writes_rd;
    logic             illegal;
  } dec_fields_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, execute-side, writeback and flush signals of the decode stage.
// The stage uses the slave modport; the surrounding pipeline drives the master side.
interface decode_stage_if
  import arctos_isa_pkg::*;
#(
  parameter int XLEN = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_opcode;
  logic [3:0]         out_alu_func;
  logic [REG_W-1:0]   out_rd;
  logic [REG_W-1:0]   out_rs1;
  logic [REG_W-1:0]   out_rs2;
  logic [XLEN-1:0]    out_imm;
  logic               out_mem_rw;
  logic [22:0]        out_mem_addr;
  logic [1:0]         out_branch_type;
  logic [26:0]        out_inst_addr;
  logic               out_writes_rd;
  logic               out_illegal;

  logic               wb_valid;
  logic [REG_W-1:0]   wb_rd;
  logic               flush;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_opcode, out_alu_func, out_rd, out_rs1, out_rs2,
           out_imm, out_mem_rw, out_mem_addr, out_branch_type, out_inst_addr,
           out_writes_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_opcode, out_alu_func, out_rd, out_rs1, out_rs2,
           out_imm, out_mem_rw, out_mem_addr, out_branch_type, out_inst_addr,
           out_writes_rd, out_illegal
  );
endinterface

// File: rtl/decode_fields.sv
// Combinational Arctos32 field extractor: splits an instruction into operand/control
// fields, sign-extends immediates and reports register usage for hazard checking.
module decode_fields
  import arctos_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_fields_t        fields,
  output logic [XLEN-1:0]    imm,
  output logic               uses_rs1,
  output logic               uses_rs2
);

  logic rd_written;

  always_comb begin
    fields        = '0;
    imm           = '0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    rd_written    = 1'b0;
    fields.opcode = instr[OPC_HI:OPC_LO];
    case (fields.opcode)
      OP_RR: begin
        fields.alu_func = instr[FUNC_HI:FUNC_LO];
        fields.rd       = instr[RD_HI:RD_LO];
        fields.rs1      = instr[RS1_HI:RS1_LO];
        fields.rs2      = instr[RS2_HI:RS2_LO];
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        rd_written      = 1'b1;
      end
      OP_IMM: begin
        fields.alu_func = instr[FUNC_HI:FUNC_LO];
        fields.rd       = instr[RD_HI:RD_LO];
        fields.rs1      = instr[RS1_HI:RS1_LO];
        imm             = {{(XLEN-15){instr[14]}}, instr[14:0]};
        uses_rs1        = 1'b1;
        rd_written      = 1'b1;
      end
      OP_LOADIMM: begin
        fields.rd  = instr[LIRD_HI:LIRD_LO];
        imm        = {{(XLEN-24){instr[23]}}, instr[23:0]};
        rd_written = 1'b1;
      end
      OP_MEM: begin
        // The same register slot is the store base or the load destination.
        fields.mem_rw   = instr[MEMRW_B];
        fields.mem_addr = instr[22:0];
        if (instr[MEMRW_B]) begin
          fields.rs1 = instr[MEMREG_HI:MEMREG_LO];
          uses_rs1   = 1'b1;
        end else begin
          fields.rd  = instr[MEMREG_HI:MEMREG_LO];
          rd_written = 1'b1;
        end
      end
      OP_BRANCH: begin
        fields.branch_type = instr[BTYPE_HI:BTYPE_LO];
        fields.inst_addr   = instr[26:0];
      end
      default: fields.illegal = 1'b1;
    endcase
    fields.writes_rd = rd_written && (fields.rd != '0);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage: one-deep output register plus a pending-write
// scoreboard that stalls fetch on RAW/WAW hazards until writeback retires the register.
module decode_stage
  import arctos_isa_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave dbus
);

  dec_fields_t      dec_fields;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_uses_rs1;
  logic             dec_uses_rs2;

  dec_fields_t      fields_reg;
  logic [XLEN-1:0]  imm_reg;
  logic             out_valid_reg;
  logic [NREGS-1:0] pending_reg;
  logic [NREGS-1:0] pending_next;

  logic [NREGS-1:0] rs1_hit, rs2_hit, rd_hit;
  logic             hazard, issue, accept, in_ready_int;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instr    (dbus.in_instr),
    .fields   (dec_fields),
    .imm      (dec_imm),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  assign issue = out_valid_reg && dbus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      // A register is busy if already pending or about to be written by the held entry.
      logic busy;
      assign busy = pending_reg[gi] ||
                    (out_valid_reg && fields_reg.writes_rd && fields_reg.rd == REG_W'(gi));
      assign rs1_hit[gi] = busy && (dec_fields.rs1 == REG_W'(gi));
      assign rs2_hit[gi] = busy && (dec_fields.rs2 == REG_W'(gi));
      assign rd_hit[gi]  = busy && (dec_fields.rd  == REG_W'(gi));

      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_track
        logic set_bit, clr_bit;
        assign set_bit = issue && fields_reg.writes_rd && fields_reg.rd == REG_W'(gi);
        assign clr_bit = dbus.wb_valid && dbus.wb_rd == REG_W'(gi);
        assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
      end
    end
  endgenerate

  assign hazard = (dec_uses_rs1 && |rs1_hit) ||
                  (dec_uses_rs2 && |rs2_hit) ||
                  (dec_fields.writes_rd && |rd_hit);

  assign in_ready_int = !reset && !hazard && (!out_valid_reg || dbus.out_ready) && !dbus.flush;
  assign accept       = dbus.in_valid && in_ready_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      fields_reg    <= '0;
      imm_reg       <= '0;
      pending_reg   <= '0;
    end else begin
      pending_reg <= pending_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        fields_reg    <= dec_fields;
        imm_reg       <= dec_imm;
      end else if (issue || dbus.flush) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign dbus.in_ready        = in_ready_int;
  assign dbus.out_valid       = out_valid_reg;
  assign dbus.out_opcode      = fields_reg.opcode;
  assign dbus.out_alu_func    = fields_reg.alu_func;
  assign dbus.out_rd          = fields_reg.rd;
  assign dbus.out_rs1         = fields_reg.rs1;
  assign dbus.out_rs2         = fields_reg.rs2;
  assign dbus.out_imm         = imm_reg;
  assign dbus.out_mem_rw      = fields_reg.mem_rw;
  assign dbus.out_mem_addr    = fields_reg.mem_addr;
  assign dbus.out_branch_type = fields_reg.branch_type;
  assign dbus.out_inst_addr   = fields_reg.inst_addr;
  assign dbus.out_writes_rd   = fields_reg.writes_rd;
  assign dbus.out_illegal     = fields_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus queues hand-computed decodes, a monitor
// compares them on every execute-side transfer; stall/flush/reset checks are inline.
module tb_decode_stage;
  import arctos_isa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) dif ();
  decode_stage #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .reset(reset), .dbus(dif));

  typedef struct {
    logic [2:0]  opcode;
    logic [3:0]  func;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        rw;
    logic [22:0] addr;
    logic [1:0]  bt;
    logic [26:0] ia;
    logic        wr;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   waited;

  function automatic exp_t mk(logic [2:0] op, logic [3:0] fn, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [31:0] imm, logic rw, logic [22:0] addr,
                              logic [1:0] bt, logic [26:0] ia, logic wr, logic ill);
    exp_t e;
    e.opcode = op; e.func = fn; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.rw = rw; e.addr = addr; e.bt = bt; e.ia = ia; e.wr = wr; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] instr, input exp_t e, output int w);
    dif.in_instr = instr;
    dif.in_valid = 1'b1;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dif.in_ready) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        return;
      end
      w++;
    end
    n_vec++;
    n_err++;
    $display("FAIL accept_timeout: instr 0x%08h not accepted in %0d cycles", instr, w);
    dif.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && dif.out_valid && dif.out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: opcode 0x%0h rd %0d with nothing expected",
                 dif.out_opcode, dif.out_rd);
      end else begin
        mon_e = q.pop_front();
        chk("out_opcode",      dif.out_opcode,      mon_e.opcode);
        chk("out_alu_func",    dif.out_alu_func,    mon_e.func);
        chk("out_rd",          dif.out_rd,          mon_e.rd);
        chk("out_rs1",         dif.out_rs1,         mon_e.rs1);
        chk("out_rs2",         dif.out_rs2,         mon_e.rs2);
        chk("out_imm",         dif.out_imm,         mon_e.imm);
        chk("out_mem_rw",      dif.out_mem_rw,      mon_e.rw);
        chk("out_mem_addr",    dif.out_mem_addr,    mon_e.addr);
        chk("out_branch_type", dif.out_branch_type, mon_e.bt);
        chk("out_inst_addr",   dif.out_inst_addr,   mon_e.ia);
        chk("out_writes_rd",   dif.out_writes_rd,   mon_e.wr);
        chk("out_illegal",     dif.out_illegal,     mon_e.ill);
      end
    end
  end

  initial begin
    dif.in_valid  = 1'b0;
    dif.in_instr  = '0;
    dif.out_ready = 1'b0;
    dif.wb_valid  = 1'b0;
    dif.wb_rd     = '0;
    dif.flush     = 1'b0;
    reset         = 1'b1;

    #12;
    chk("reset_out_valid", dif.out_valid, 0);
    chk("reset_out_rd",    dif.out_rd, 0);
    chk("reset_out_imm",   dif.out_imm, 0);
    chk("reset_pending",   dut.pending_reg, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", dif.in_ready, 1);
    tick();

    // Back-to-back RR / IMM / LOADIMM at full throughput
    dif.out_ready = 1'b1;
    send(32'h0030_8800, mk(3'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    chk("rr_accept_wait", waited, 0);
    send(32'h2040_C001, mk(3'd1, 4'd0, 5'd4, 5'd1, 5'd0, 32'hFFFF_C001, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    chk("imm_accept_wait", waited, 0);
    send(32'h457F_FFFF, mk(3'd2, 4'd0, 5'd5, 5'd0, 5'd0, 32'h007F_FFFF, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    chk("li_accept_wait", waited, 0);
    chk("pending3_set", dut.pending_reg[3], 1);

    // RAW stall on r5, released by writeback one cycle later
    dif.in_instr = 32'h0262_8000;
    dif.in_valid = 1'b1;
    @(negedge clk);
    chk("raw_stall_outreg", dif.in_ready, 0);
    tick();
    @(negedge clk);
    chk("raw_stall_pending", dif.in_ready, 0);
    tick();
    dif.wb_valid = 1'b1;
    dif.wb_rd    = 5'd5;
    @(negedge clk);
    chk("raw_no_bypass", dif.in_ready, 0);
    tick();
    dif.wb_valid = 1'b0;
    send(32'h0262_8000, mk(3'd0, 4'd1, 5'd6, 5'd5, 5'd0, 32'h0, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    chk("raw_release_wait", waited, 0);
    tick();

    // Backpressure: load held for 3 cycles, store accepted in the release cycle
    dif.out_ready = 1'b0;
    send(32'h6401_2345, mk(3'd3, 4'd0, 5'd8, 5'd0, 5'd0, 32'h0, 1'b0, 23'h012345, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    dif.in_instr = 32'h74FF_FFFF;
    dif.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  dif.in_ready, 0);
      chk("bp_out_valid", dif.out_valid, 1);
      chk("bp_out_rd",    dif.out_rd, 8);
      chk("bp_mem_addr",  dif.out_mem_addr, 23'h012345);
      tick();
    end
    dif.out_ready = 1'b1;
    send(32'h74FF_FFFF, mk(3'd3, 4'd0, 5'd0, 5'd9, 5'd0, 32'h0, 1'b1, 23'h7FFFFF, 2'd0, 27'h0, 1'b0, 1'b0), waited);
    chk("bp_release_wait", waited, 0);
    tick();

    // Flush a held entry: dropped, nothing accepted, scoreboard untouched
    dif.out_ready = 1'b0;
    send(32'h04A0_0000, mk(3'd0, 4'd2, 5'd10, 5'd0, 5'd0, 32'h0, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    dif.flush    = 1'b1;
    dif.in_instr = 32'h90AB_CDEF;
    dif.in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", dif.in_ready, 0);
    tick();
    dif.flush    = 1'b0;
    dif.in_valid = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("flush_out_valid", dif.out_valid, 0);
    chk("flush_pending",   dut.pending_reg, 32'h0000_0158);
    tick();

    // Branch, illegal, then flush coinciding with issue of LOADIMM r12
    dif.out_ready = 1'b1;
    send(32'h90AB_CDEF, mk(3'd4, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 23'h0, 2'd2, 27'h0ABCDEF, 1'b0, 1'b0), waited);
    send(32'hC123_4567, mk(3'd6, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 23'h0, 2'd0, 27'h0, 1'b0, 1'b1), waited);
    send(32'h4C00_0000, mk(3'd2, 4'd0, 5'd12, 5'd0, 5'd0, 32'h0, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
    @(negedge clk);
    chk("issue_flush_pending", dut.pending_reg, 32'h0000_1158);
    chk("issue_flush_valid",   dif.out_valid, 0);
    tick();

    // Reset asserted mid-stall on r7 with a held entry
    send(32'h4700_0001, mk(3'd2, 4'd0, 5'd7, 5'd0, 5'd0, 32'h1, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    tick();
    dif.out_ready = 1'b0;
    send(32'h8800_0010, mk(3'd4, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 23'h0, 2'd1, 27'h10, 1'b0, 1'b0), waited);
    dif.in_instr = 32'h00B3_8000;
    dif.in_valid = 1'b1;
    @(negedge clk);
    chk("r7_stall", dif.in_ready, 0);
    chk("r7_pending", dut.pending_reg, 32'h0000_11D8);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid",   dif.out_valid, 0);
    chk("async_reset_pending", dut.pending_reg, 0);
    chk("async_reset_btype",   dif.out_branch_type, 0);
    chk("async_reset_iaddr",   dif.out_inst_addr, 0);
    q.delete();
    dif.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_midreset", dif.in_ready, 1);
    tick();
    dif.out_ready = 1'b1;
    send(32'h00B3_8000, mk(3'd0, 4'd0, 5'd11, 5'd7, 5'd0, 32'h0, 1'b0, 23'h0, 2'd0, 27'h0, 1'b1, 1'b0), waited);
    chk("post_reset_accept_wait", waited, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d expected outputs never appeared", q.size());
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
